// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fnd_scan_ctrl
// Purpose  : 4-digit common-anode 7-segment scanner with per-frame input
//            snapshot and packed BCD of the lower digit pair.
//            Optional macro LEADING_ZERO_BLANK_EN blanks a zero on digit 3.
// Revision : 1.0 - initial release
// ============================================================================
module fnd_scan_ctrl #(
    parameter int SCAN_DIV   = 100_000,
    parameter int BLINK_HALF = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw,
    input  logic [6:0] msec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_com,
    output logic [7:0] fnd_data,
    output logic [7:0] time_data
);

    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]       DP_LIMIT = 7'(BLINK_HALF);

    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       digit;
    logic [6:0]       snap_msec;
    logic [5:0]       snap_sec;
    logic [5:0]       snap_min;
    logic [4:0]       snap_hour;
    logic             sw_q;

    logic             slot_end;
    logic             frame_end;
    logic [6:0]       field_hi;
    logic [6:0]       field_lo;
    logic [7:0]       hi_bcd;
    logic [7:0]       lo_bcd;
    logic [3:0]       digit_val;
    logic [7:0]       seg_next;
    logic [3:0]       com_next;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'((v / 7'd10) % 7'd10);
        ones = 4'(v % 7'd10);
        return {tens, ones};
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign slot_end  = (scan_cnt == CNT_LAST);
    assign frame_end = slot_end && (digit == 2'd3);

    // Snapshot is taken only as digit 3 hands over to digit 0, so a frame never mixes old and new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit     <= 2'd0;
            snap_msec <= '0;
            snap_sec  <= '0;
            snap_min  <= '0;
            snap_hour <= '0;
            sw_q      <= 1'b0;
        end else begin
            scan_cnt <= slot_end ? '0 : scan_cnt + 1'b1;
            if (slot_end) begin
                digit <= digit + 2'd1;
            end
            if (frame_end) begin
                snap_msec <= msec;
                snap_sec  <= sec;
                snap_min  <= min;
                snap_hour <= hour;
                sw_q      <= sw;
            end
        end
    end

    always_comb begin
        field_hi = sw_q ? {2'b00, snap_hour} : {1'b0, snap_sec};
        field_lo = sw_q ? {1'b0, snap_min}   : snap_msec;
        hi_bcd   = to_bcd(field_hi);
        lo_bcd   = to_bcd(field_lo);

        case (digit)
            2'd0:    digit_val = lo_bcd[3:0];
            2'd1:    digit_val = lo_bcd[7:4];
            2'd2:    digit_val = hi_bcd[3:0];
            default: digit_val = hi_bcd[7:4];
        endcase

        seg_next = seg7(digit_val);
        if ((digit == 2'd2) && (snap_msec < DP_LIMIT)) begin
            seg_next[7] = 1'b0;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if ((digit == 2'd3) && (digit_val == 4'd0)) begin
            seg_next = 8'hFF;
        end
`endif
        com_next = ~(4'b0001 << digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fnd_com   <= 4'b1111;
            fnd_data  <= 8'hFF;
            time_data <= 8'h00;
        end else begin
            fnd_com   <= com_next;
            fnd_data  <= seg_next;
            time_data <= lo_bcd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnd_scan_ctrl
// Purpose  : Directed self-checking bench for fnd_scan_ctrl (SCAN_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw  = 1'b0;
    logic [6:0] msec = '0;
    logic [5:0] sec  = '0;
    logic [5:0] min  = '0;
    logic [4:0] hour = '0;
    logic [3:0] fnd_com;
    logic [7:0] fnd_data;
    logic [7:0] time_data;

    int checks = 0;
    int errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] D3_ZERO = 8'hFF;
`else
    localparam logic [7:0] D3_ZERO = 8'hC0;
`endif

    always #5 clk = ~clk;

    fnd_scan_ctrl #(.SCAN_DIV(4), .BLINK_HALF(50)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .msec      (msec),
        .sec       (sec),
        .min       (min),
        .hour      (hour),
        .fnd_com   (fnd_com),
        .fnd_data  (fnd_data),
        .time_data (time_data)
    );

    // Returns at the first negedge of a frame whose snapshot was taken after the call.
    task automatic sync_frame(output bit ok);
        logic [3:0] prev;
        prev = 4'b0000;
        ok   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && fnd_com == 4'b1110) begin
                ok = 1'b1;
                break;
            end
            prev = fnd_com;
        end
    endtask

    task automatic capture_frame(output logic [3:0][7:0] seg, output logic [3:0][3:0] com,
                                 output logic [7:0] td);
        seg[0] = fnd_data;
        com[0] = fnd_com;
        td     = time_data;
        for (int i = 1; i < 4; i++) begin
            repeat (4) @(negedge clk);
            seg[i] = fnd_data;
            com[i] = fnd_com;
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_com [4];
        exp_com = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (fnd_com !== 4'b1111) begin errors++; $display("FAIL reset_com got=%b exp=1111", fnd_com); end
        checks++; if (fnd_data !== 8'hFF) begin errors++; $display("FAIL reset_data got=%h exp=ff", fnd_data); end
        checks++; if (time_data !== 8'h00) begin errors++; $display("FAIL reset_time got=%h exp=00", time_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (fnd_com !== 4'b1110) begin errors++; $display("FAIL first_com got=%b exp=1110", fnd_com); end
        checks++; if (fnd_data !== 8'hC0) begin errors++; $display("FAIL first_data got=%h exp=c0", fnd_data); end
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clk);
            checks++;
            if (fnd_com !== exp_com[i]) begin
                errors++; $display("FAIL scan_step%0d got=%b exp=%b", i, fnd_com, exp_com[i]);
            end
        end
    endtask

    task automatic test_sec_msec();
        bit ok;
        logic [3:0][7:0] seg;
        logic [3:0][3:0] com;
        logic [7:0]      td;
        logic [3:0][7:0] exp;
        exp = {8'hB0, 8'h78, 8'h99, 8'hA4};
        sw = 1'b0; sec = 6'd37; msec = 7'd42;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL sec_msec_sync got=timeout exp=frame"); end
        capture_frame(seg, com, td);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seg[i] !== exp[i]) begin errors++; $display("FAIL sec_msec_d%0d got=%h exp=%h", i, seg[i], exp[i]); end
        end
        checks++; if (com[2] !== 4'b1011) begin errors++; $display("FAIL sec_msec_com2 got=%b exp=1011", com[2]); end
        checks++; if (td !== 8'h42) begin errors++; $display("FAIL sec_msec_time got=%h exp=42", td); end
    endtask

    task automatic test_hour_min();
        bit ok;
        logic [3:0][7:0] seg;
        logic [3:0][3:0] com;
        logic [7:0]      td;
        logic [3:0][7:0] exp;
        exp = {D3_ZERO, 8'h10, 8'hC0, 8'h92};
        sw = 1'b1; hour = 5'd9; min = 6'd5;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL hour_min_sync got=timeout exp=frame"); end
        capture_frame(seg, com, td);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (seg[i] !== exp[i]) begin errors++; $display("FAIL hour_min_d%0d got=%h exp=%h", i, seg[i], exp[i]); end
        end
        checks++; if (com[3] !== 4'b0111) begin errors++; $display("FAIL hour_min_com3 got=%b exp=0111", com[3]); end
        checks++; if (td !== 8'h05) begin errors++; $display("FAIL hour_min_time got=%h exp=05", td); end
    endtask

    task automatic test_snapshot_hold();
        bit ok;
        sw = 1'b0; sec = 6'd37; msec = 7'd10;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_sync got=timeout exp=frame"); end
        checks++; if (fnd_data !== 8'hC0) begin errors++; $display("FAIL hold_old_d0 got=%h exp=c0", fnd_data); end
        repeat (4) @(negedge clk);
        checks++; if (fnd_data !== 8'hF9) begin errors++; $display("FAIL hold_old_d1 got=%h exp=f9", fnd_data); end
        msec = 7'd77;
        repeat (4) @(negedge clk);
        checks++; if (fnd_data !== 8'h78) begin errors++; $display("FAIL hold_old_d2 got=%h exp=78", fnd_data); end
        checks++; if (time_data !== 8'h10) begin errors++; $display("FAIL hold_old_time got=%h exp=10", time_data); end
        repeat (4) @(negedge clk);
        checks++; if (fnd_data !== 8'hB0) begin errors++; $display("FAIL hold_old_d3 got=%h exp=b0", fnd_data); end
        repeat (4) @(negedge clk);
        checks++; if (fnd_data !== 8'hF8) begin errors++; $display("FAIL hold_new_d0 got=%h exp=f8", fnd_data); end
        checks++; if (time_data !== 8'h77) begin errors++; $display("FAIL hold_new_time got=%h exp=77", time_data); end
        repeat (4) @(negedge clk);
        checks++; if (fnd_data !== 8'hF8) begin errors++; $display("FAIL hold_new_d1 got=%h exp=f8", fnd_data); end
        repeat (4) @(negedge clk);
        checks++; if (fnd_data !== 8'hF8) begin errors++; $display("FAIL hold_new_d2 got=%h exp=f8", fnd_data); end
    endtask

    task automatic test_mode_toggle();
        bit ok;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL toggle_sync got=timeout exp=frame"); end
        repeat (8) @(negedge clk);
        checks++; if (fnd_data !== 8'hF8) begin errors++; $display("FAIL toggle_pre_d2 got=%h exp=f8", fnd_data); end
        sw = 1'b1; hour = 5'd9; min = 6'd5;
        repeat (4) @(negedge clk);
        checks++; if (fnd_data !== 8'hB0) begin errors++; $display("FAIL toggle_old_d3 got=%h exp=b0", fnd_data); end
        repeat (4) @(negedge clk);
        checks++; if (fnd_data !== 8'h92) begin errors++; $display("FAIL toggle_new_d0 got=%h exp=92", fnd_data); end
        checks++; if (time_data !== 8'h05) begin errors++; $display("FAIL toggle_new_time got=%h exp=05", time_data); end
        repeat (4) @(negedge clk);
        checks++; if (fnd_data !== 8'hC0) begin errors++; $display("FAIL toggle_new_d1 got=%h exp=c0", fnd_data); end
        repeat (4) @(negedge clk);
        checks++; if (fnd_data !== 8'h90) begin errors++; $display("FAIL toggle_new_d2 got=%h exp=90", fnd_data); end
        repeat (4) @(negedge clk);
        checks++; if (fnd_data !== D3_ZERO) begin errors++; $display("FAIL toggle_new_d3 got=%h exp=%h", fnd_data, D3_ZERO); end
    endtask

    task automatic test_reset_mid_scan();
        bit ok;
        sync_frame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_sync got=timeout exp=frame"); end
        repeat (9) @(negedge clk);
        checks++; if (fnd_com !== 4'b1011) begin errors++; $display("FAIL midrst_pre_com got=%b exp=1011", fnd_com); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (fnd_com !== 4'b1111) begin errors++; $display("FAIL midrst_com got=%b exp=1111", fnd_com); end
        checks++; if (fnd_data !== 8'hFF) begin errors++; $display("FAIL midrst_data got=%h exp=ff", fnd_data); end
        checks++; if (time_data !== 8'h00) begin errors++; $display("FAIL midrst_time got=%h exp=00", time_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (fnd_com !== 4'b1110) begin errors++; $display("FAIL midrst_restart_com got=%b exp=1110", fnd_com); end
        checks++; if (fnd_data !== 8'hC0) begin errors++; $display("FAIL midrst_restart_data got=%h exp=c0", fnd_data); end
        repeat (3) @(negedge clk);
        checks++; if (fnd_com !== 4'b1110) begin errors++; $display("FAIL midrst_slot_end got=%b exp=1110", fnd_com); end
        @(negedge clk);
        checks++; if (fnd_com !== 4'b1101) begin errors++; $display("FAIL midrst_next_slot got=%b exp=1101", fnd_com); end
    endtask

    initial begin
        test_reset();
        test_sec_msec();
        test_hour_min();
        test_snapshot_hold();
        test_mode_toggle();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
